// File: rtl/forward_table_pkg.sv
// Shared definitions for the forward-lookup table: RAM geometry, read
// latency and the arbiter state encoding used by the lookup/forwarding blocks.
package forward_table_pkg;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 9;
    localparam int RD_LAT = 2;

    typedef enum logic [1:0] {
        ST_INIT        = 2'd0,
        ST_IDLE        = 2'd1,
        ST_CFG_PEND    = 2'd2,
        ST_CFG_RD_WAIT = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_LOOKUP = 1'b0,
        OWN_CFG    = 1'b1
    } tag_owner_e;

    typedef struct packed {
        logic       valid;
        tag_owner_e owner;
    } rd_tag_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// Read-tag pipeline: follows every RAM read for RD_LAT cycles so the
// arbiter knows which returning data word belongs to the config path.
module rd_tag_pipe
    import forward_table_pkg::*;
#(
    parameter int DEPTH = RD_LAT
) (
    input  logic    i_clk,
    input  logic    i_clr,
    input  rd_tag_t i_tag,
    output rd_tag_t o_tag
);

    rd_tag_t pipe_q [DEPTH];

    // Shift one slot per cycle; a clear drops every in-flight tag.
    // NOTE: clocked state uses non-blocking assignments so every stage samples the old value of its neighbour.
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= i_tag;
            for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign o_tag = pipe_q[DEPTH-1];

endmodule

// File: rtl/forward_table_arbiter.sv
// Owns the single forward-lookup RAM port. Lookups get the port
// combinationally with absolute priority; the config path gets one
// outstanding request at a time; after reset the RAM is swept to INIT_VAL.
module forward_table_arbiter
    import forward_table_pkg::*;
#(
    parameter logic [DATA_W-1:0] INIT_VAL   = '0,
    parameter int                STARVE_MAX = 64
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [ADDR_W-1:0] iv_lookup_raddr,
    input  logic              i_lookup_rd,
    input  logic [ADDR_W-1:0] iv_cfg_addr,
    input  logic [DATA_W-1:0] iv_cfg_wdata,
    input  logic              i_cfg_wr,
    input  logic              i_cfg_rd,
    output logic              o_cfg_ready,
    output logic [DATA_W-1:0] ov_cfg_rdata,
    output logic              o_cfg_rdata_valid,
    output logic              o_init_done,
    output logic              o_cfg_starve,
    output logic [ADDR_W-1:0] ov_ram_addr,
    output logic [DATA_W-1:0] ov_ram_wdata,
    output logic              o_ram_wr,
    output logic              o_ram_rd,
    input  logic [DATA_W-1:0] iv_ram_rdata
);

    localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;
    localparam int                STV_W      = $clog2(STARVE_MAX + 1);
    localparam logic [STV_W-1:0]  STARVE_LIM = STV_W'(STARVE_MAX);

    arb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
    logic              req_wr_q, req_wr_d;
    logic [STV_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic              starve_q, starve_d;
    logic              init_done_q, init_done_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rdata_valid_q, rdata_valid_d;
    logic              cfg_issue;
    rd_tag_t           tag_in, tag_out;

    // Ready is withheld during the rdata_valid cycle so a read completes before the next handshake.
    assign o_cfg_ready       = (state_q == ST_IDLE) && !rdata_valid_q;
    assign ov_cfg_rdata      = rdata_q;
    assign o_cfg_rdata_valid = rdata_valid_q;
    assign o_init_done       = init_done_q;
    assign o_cfg_starve      = starve_q;

    // Next-state logic: init sweep, config capture/issue, read return, starvation tracking.
    // NOTE: every variable gets its default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_d       = state_q;
        init_cnt_d    = init_cnt_q;
        req_addr_d    = req_addr_q;
        req_wdata_d   = req_wdata_q;
        req_wr_d      = req_wr_q;
        starve_cnt_d  = starve_cnt_q;
        init_done_d   = init_done_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        cfg_issue     = 1'b0;

        case (state_q)
            ST_INIT: begin
                if (!i_lookup_rd) begin
                    init_cnt_d = init_cnt_q + ADDR_W'(1);
                    if (init_cnt_q == LAST_ADDR) begin
                        state_d     = ST_IDLE;
                        init_done_d = 1'b1;
                    end
                end
            end
            ST_IDLE: begin
                if ((i_cfg_wr || i_cfg_rd) && o_cfg_ready) begin
                    req_addr_d  = iv_cfg_addr;
                    req_wdata_d = iv_cfg_wdata;
                    req_wr_d    = i_cfg_wr;
                    state_d     = ST_CFG_PEND;
                end
            end
            ST_CFG_PEND: begin
                if (i_lookup_rd) begin
                    if (starve_cnt_q != STARVE_LIM) starve_cnt_d = starve_cnt_q + STV_W'(1);
                end else begin
                    cfg_issue    = 1'b1;
                    starve_cnt_d = '0;
                    state_d      = req_wr_q ? ST_IDLE : ST_CFG_RD_WAIT;
                end
            end
            ST_CFG_RD_WAIT: begin
                if (tag_out.valid && (tag_out.owner == OWN_CFG)) begin
                    rdata_d       = iv_ram_rdata;
                    rdata_valid_d = 1'b1;
                    state_d       = ST_IDLE;
                end
            end
            default: state_d = ST_INIT;
        endcase

        starve_d = starve_q || (starve_cnt_d == STARVE_LIM);
    end

    // RAM port mux: lookup first, then the registered internal request, else idle.
    always_comb begin
        ov_ram_addr  = '0;
        ov_ram_wdata = '0;
        o_ram_wr     = 1'b0;
        o_ram_rd     = 1'b0;
        if (i_lookup_rd) begin
            ov_ram_addr = iv_lookup_raddr;
            o_ram_rd    = 1'b1;
        end else if (!i_rst) begin
            if (state_q == ST_INIT) begin
                ov_ram_addr  = init_cnt_q;
                ov_ram_wdata = INIT_VAL;
                o_ram_wr     = 1'b1;
            end else if (state_q == ST_CFG_PEND) begin
                ov_ram_addr  = req_addr_q;
                ov_ram_wdata = req_wr_q ? req_wdata_q : '0;
                o_ram_wr     = req_wr_q;
                o_ram_rd     = !req_wr_q;
            end
        end
    end

    assign tag_in.valid = o_ram_rd;
    assign tag_in.owner = (cfg_issue && !req_wr_q) ? OWN_CFG : OWN_LOOKUP;

    rd_tag_pipe #(.DEPTH(RD_LAT)) u_tag_pipe (
        .i_clk (i_clk),
        .i_clr (i_rst),
        .i_tag (tag_in),
        .o_tag (tag_out)
    );

    // State and datapath registers with synchronous reset.
    // NOTE: the RAM itself is never reset; the init sweep is what gives it a defined content.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= ST_INIT;
            init_cnt_q    <= '0;
            req_addr_q    <= '0;
            req_wdata_q   <= '0;
            req_wr_q      <= 1'b0;
            starve_cnt_q  <= '0;
            starve_q      <= 1'b0;
            init_done_q   <= 1'b0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            init_cnt_q    <= init_cnt_d;
            req_addr_q    <= req_addr_d;
            req_wdata_q   <= req_wdata_d;
            req_wr_q      <= req_wr_d;
            starve_cnt_q  <= starve_cnt_d;
            starve_q      <= starve_d;
            init_done_q   <= init_done_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
        end
    end

endmodule

// File: tb/tb_forward_table_arbiter.sv
// Bench for forward_table_arbiter: RAM model with RD_LAT read pipeline,
// reference table contents and an expected-read queue.
module tb_forward_table_arbiter;
    import forward_table_pkg::*;

    localparam logic [DATA_W-1:0] INIT_VAL = 9'h0;
    localparam int                DEPTH    = 2 ** ADDR_W;

    logic              clk = 1'b0;
    logic              i_rst;
    logic [ADDR_W-1:0] lk_addr;
    logic              lk_rd;
    logic [ADDR_W-1:0] cfg_addr;
    logic [DATA_W-1:0] cfg_wdata;
    logic              cfg_wr, cfg_rd;
    logic              cfg_ready, rdata_valid, init_done, starve;
    logic [DATA_W-1:0] cfg_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata, ram_rdata;
    logic              ram_wr, ram_rd;

    int n_checks = 0;
    int n_errors = 0;

    always #4 clk = ~clk;

    forward_table_arbiter #(.INIT_VAL(INIT_VAL), .STARVE_MAX(64)) dut (
        .i_clk             (clk),
        .i_rst             (i_rst),
        .iv_lookup_raddr   (lk_addr),
        .i_lookup_rd       (lk_rd),
        .iv_cfg_addr       (cfg_addr),
        .iv_cfg_wdata      (cfg_wdata),
        .i_cfg_wr          (cfg_wr),
        .i_cfg_rd          (cfg_rd),
        .o_cfg_ready       (cfg_ready),
        .ov_cfg_rdata      (cfg_rdata),
        .o_cfg_rdata_valid (rdata_valid),
        .o_init_done       (init_done),
        .o_cfg_starve      (starve),
        .ov_ram_addr       (ram_addr),
        .ov_ram_wdata      (ram_wdata),
        .o_ram_wr          (ram_wr),
        .o_ram_rd          (ram_rd),
        .iv_ram_rdata      (ram_rdata)
    );

    // Single-port RAM model, data RD_LAT cycles after the read address.
    logic [DATA_W-1:0] mem     [DEPTH];
    logic [DATA_W-1:0] rd_pipe [RD_LAT];
    always @(posedge clk) begin
        if (ram_wr) mem[ram_addr] <= ram_wdata;
        rd_pipe[0] <= mem[ram_addr];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_rdata = rd_pipe[RD_LAT-1];

    // Reference model: what the table should contain and what reads must return.
    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic [DATA_W-1:0] exp_rd [$];

    typedef struct {
        logic              lk;
        logic [ADDR_W-1:0] la;
        logic              exp_rd;
        logic [ADDR_W-1:0] exp_addr;
    } vec_t;
    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_quiet();
        lk_rd = 1'b0; lk_addr = '0;
        cfg_wr = 1'b0; cfg_rd = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    endtask

    // Wait for o_cfg_rdata_valid; the caller is one cycle past the issue (lat=1).
    task automatic wait_rdata(output int lat);
        lat = 1;
        while (!rdata_valid && lat < 12) begin
            @(negedge clk); #1;
            lat++;
        end
    endtask

    // Reset, then watch the full init sweep; alt_lk puts a lookup in every other cycle.
    task automatic reset_and_sweep(input bit alt_lk);
        int cyc, nwr, bad;
        logic [ADDR_W-1:0] exp_a;
        i_rst = 1'b1;
        drive_quiet();
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", 32'({cfg_ready, init_done, rdata_valid, starve, ram_wr, ram_rd, cfg_rdata}), 32'h0);
        i_rst = 1'b0;
        nwr = 0; bad = 0; exp_a = '0;
        for (cyc = 0; cyc < 40000 && !init_done; cyc++) begin
            lk_rd   = alt_lk && (cyc % 2 == 0);
            lk_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
            #1;
            if (cfg_ready) bad++;
            if (lk_rd) begin
                if (!(ram_rd && !ram_wr && ram_addr == lk_addr)) bad++;
            end else if (ram_wr && !ram_rd && ram_addr == exp_a && ram_wdata == INIT_VAL) begin
                exp_a++;
                nwr++;
            end else begin
                bad++;
            end
            @(negedge clk);
        end
        lk_rd = 1'b0;
        #1;
        check("init_done", 32'(init_done), 32'd1);
        check("init_write_count", 32'(nwr), 32'(DEPTH));
        check("init_sweep_errors", 32'(bad), 32'd0);
        if (alt_lk) check("init_cycles_alt", 32'(cyc >= 2*DEPTH - 1 && cyc <= 2*DEPTH + 1), 32'd1);
        else        check("init_cycles", 32'(cyc), 32'(DEPTH));
        check("idle_port_quiet", 32'({ram_wr, ram_rd, cfg_ready}), 32'b001);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = INIT_VAL;
    endtask

    initial begin
        #(8 * 99000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat, bad;
        bit seen;
        logic req_act, req_w, req_r, pend_w;
        logic [ADDR_W-1:0] req_a, pend_a;
        logic [DATA_W-1:0] req_d, pend_d, exp_v;

        vecs[0] = '{1'b1, 14'h0000, 1'b1, 14'h0000};
        vecs[1] = '{1'b1, 14'h3FFF, 1'b1, 14'h3FFF};
        vecs[2] = '{1'b0, 14'h1234, 1'b0, 14'h0000};
        vecs[3] = '{1'b1, 14'h0123, 1'b1, 14'h0123};
        vecs[4] = '{1'b0, 14'h3FFF, 1'b0, 14'h0000};
        vecs[5] = '{1'b1, 14'h2AAA, 1'b1, 14'h2AAA};

        // Sweep without lookups.
        reset_and_sweep(1'b0);

        // Write 0x0123 <- 0x1A5, then read it back, no lookups.
        @(negedge clk); cfg_wr = 1'b1; cfg_addr = 14'h0123; cfg_wdata = 9'h1A5; #1;
        check("wr_hs_ready", 32'(cfg_ready), 32'd1);
        @(negedge clk); cfg_wr = 1'b0; #1;
        check("wr_issue", 32'({ram_wr, ram_rd, ram_addr, ram_wdata}), 32'({1'b1, 1'b0, 14'h0123, 9'h1A5}));
        check("wr_pend_ready", 32'(cfg_ready), 32'd0);
        ref_mem[14'h0123] = 9'h1A5;
        @(negedge clk); cfg_rd = 1'b1; cfg_addr = 14'h0123; #1;
        check("rd_hs_ready", 32'(cfg_ready), 32'd1);
        @(negedge clk); cfg_rd = 1'b0; #1;
        check("rd_issue", 32'({ram_rd, ram_wr, ram_addr}), 32'({1'b1, 1'b0, 14'h0123}));
        wait_rdata(lat);
        check("rd_latency", 32'(lat), 32'd4);
        check("rd_data", 32'(cfg_rdata), 32'h1A5);
        check("ready_in_valid_cycle", 32'(cfg_ready), 32'd0);
        @(negedge clk); #1;
        check("valid_one_pulse", 32'({rdata_valid, cfg_ready}), 32'b01);

        // A lookup of 0x0123 beats a pending config write.
        @(negedge clk); cfg_wr = 1'b1; cfg_addr = 14'h0456; cfg_wdata = 9'h0F0; #1;
        check("wr2_hs_ready", 32'(cfg_ready), 32'd1);
        @(negedge clk); cfg_wr = 1'b0; lk_rd = 1'b1; lk_addr = 14'h0123; #1;
        check("lookup_beats_cfg", 32'({ram_rd, ram_wr, ram_addr}), 32'({1'b1, 1'b0, 14'h0123}));
        @(negedge clk); lk_rd = 1'b0; #1;
        check("wr2_issue_after_lookup", 32'({ram_wr, ram_rd, ram_addr, ram_wdata}), 32'({1'b1, 1'b0, 14'h0456, 9'h0F0}));
        ref_mem[14'h0456] = 9'h0F0;

        // Port mux vectors while idle.
        for (int v = 0; v < 6; v++) begin
            @(negedge clk); lk_rd = vecs[v].lk; lk_addr = vecs[v].la; #1;
            check($sformatf("vec%0d_port", v), 32'({ram_rd, ram_wr, ram_addr}),
                  32'({vecs[v].exp_rd, 1'b0, vecs[v].exp_addr}));
            check($sformatf("vec%0d_ready", v), 32'(cfg_ready), 32'd1);
        end

        // Config read blocked by 70 consecutive lookups.
        @(negedge clk); lk_rd = 1'b0; cfg_rd = 1'b1; cfg_addr = 14'h0123; #1;
        check("starve_hs_ready", 32'(cfg_ready), 32'd1);
        bad = 0;
        for (int k = 0; k < 70; k++) begin
            @(negedge clk); cfg_rd = 1'b0; lk_rd = 1'b1; lk_addr = ADDR_W'($urandom_range(0, DEPTH - 1)); #1;
            if (!(ram_rd && !ram_wr && ram_addr == lk_addr)) bad++;
            if (k == 10) check("starve_not_yet", 32'(starve), 32'd0);
        end
        check("starve_lookup_errors", 32'(bad), 32'd0);
        @(negedge clk); lk_rd = 1'b0; #1;
        check("starve_rd_issue", 32'({ram_rd, ram_wr, ram_addr}), 32'({1'b1, 1'b0, 14'h0123}));
        check("starve_flag", 32'(starve), 32'd1);
        wait_rdata(lat);
        check("starve_rd_latency", 32'(lat), 32'd4);
        check("starve_rd_data", 32'(cfg_rdata), 32'h1A5);

        // Randomized traffic against the reference model.
        req_act = 1'b0; req_w = 1'b0; req_r = 1'b0; req_a = '0; req_d = '0;
        pend_w = 1'b0; pend_a = '0; pend_d = '0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            lk_rd   = ($urandom_range(0, 1) == 0);
            lk_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
            if (!req_act && $urandom_range(0, 2) == 0) begin
                req_act = 1'b1;
                case ($urandom_range(0, 2))
                    0:       begin req_w = 1'b1; req_r = 1'b0; end
                    1:       begin req_w = 1'b0; req_r = 1'b1; end
                    default: begin req_w = 1'b1; req_r = 1'b1; end
                endcase
                req_a = ADDR_W'($urandom_range(0, 31));
                req_d = DATA_W'($urandom);
            end
            cfg_wr = req_act && req_w;
            cfg_rd = req_act && req_r;
            cfg_addr = req_a; cfg_wdata = req_d;
            #1;
            if (lk_rd) begin
                check("rnd_lookup_port", 32'({ram_rd, ram_wr, ram_addr}), 32'({1'b1, 1'b0, lk_addr}));
            end else if (ram_wr) begin
                check("rnd_cfg_write", 32'({pend_w, ram_addr, ram_wdata}), 32'({1'b1, pend_a, pend_d}));
                pend_w = 1'b0;
            end
            if (rdata_valid) begin
                if (exp_rd.size() == 0) begin
                    check("rnd_unexpected_rdata", 32'(rdata_valid), 32'd0);
                end else begin
                    exp_v = exp_rd.pop_front();
                    check("rnd_rdata", 32'(cfg_rdata), 32'(exp_v));
                end
            end
            if (req_act && cfg_ready) begin
                if (req_w) begin
                    ref_mem[req_a] = req_d;
                    pend_w = 1'b1; pend_a = req_a; pend_d = req_d;
                end else begin
                    exp_rd.push_back(ref_mem[req_a]);
                end
                req_act = 1'b0;
            end
        end
        drive_quiet();
        for (int k = 0; k < 20 && exp_rd.size() != 0; k++) begin
            @(negedge clk); #1;
            if (rdata_valid) begin
                exp_v = exp_rd.pop_front();
                check("drain_rdata", 32'(cfg_rdata), 32'(exp_v));
            end
        end
        check("drain_queue_empty", 32'(exp_rd.size()), 32'd0);
        @(negedge clk); #1;
        check("starve_sticky", 32'(starve), 32'd1);

        // Reset while a config read is in flight.
        @(negedge clk); cfg_rd = 1'b1; cfg_addr = 14'h0005; #1;
        check("rst_rd_hs_ready", 32'(cfg_ready), 32'd1);
        @(negedge clk); cfg_rd = 1'b0; #1;
        check("rst_rd_issue", 32'({ram_rd, ram_addr}), 32'({1'b1, 14'h0005}));
        @(negedge clk); i_rst = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            seen = seen | rdata_valid;
        end
        @(negedge clk); i_rst = 1'b0; #1;
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            seen = seen | rdata_valid;
            if (!(ram_wr && ram_addr == ADDR_W'(k))) bad++;
            @(negedge clk); #1;
        end
        check("no_rdata_after_reset", 32'(seen), 32'd0);
        check("sweep_restarts_at_0", 32'(bad), 32'd0);
        check("starve_cleared_by_reset", 32'(starve), 32'd0);

        // Sweep with a lookup every other cycle.
        reset_and_sweep(1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
